// File: rtl/debug_uart_rx_pkg.sv
// Shared definitions for the debug UART receiver.
// Holds the register offsets and status bit positions that the tinyQV
// address decode and the TX side also rely on, the receive FSM state
// encoding, and a small helper for decoding tinyQV bus strobes.
package debug_uart_rx_pkg;

  // Register offsets within the debug UART peripheral window.
  localparam logic [3:0] RX_DATA_OFS   = 4'h0;
  localparam logic [3:0] RX_STATUS_OFS = 4'h4;

  // Status register bit positions.
  localparam int ST_NONEMPTY  = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAMING   = 3;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  // tinyQV strobes are active when not all-ones.
  function automatic logic is_access(input logic [1:0] strobe_n);
    return strobe_n != 2'b11;
  endfunction

endpackage

// File: rtl/debug_uart_rx_if.sv
// tinyQV data-bus slice seen by the debug UART receiver.
//   sel_data / sel_status : register selects from the top-level decode
//   data_read_n / data_write_n : tinyQV strobes, != 2'b11 means active
//   data_in   : write data
//   data_out  : read data (combinational in the peripheral)
//   data_ready: peripheral ready
interface debug_uart_rx_if;
  logic        sel_data;
  logic        sel_status;
  logic [1:0]  data_read_n;
  logic [1:0]  data_write_n;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output sel_data, sel_status, data_read_n, data_write_n, data_in,
    input  data_out, data_ready
  );

  modport slave (
    input  sel_data, sel_status, data_read_n, data_write_n, data_in,
    output data_out, data_ready
  );
endinterface

// File: rtl/debug_uart_rx_fifo.sv
// Receive byte FIFO for the debug UART.
//   clk, rst : clock, synchronous active-high reset (flushes the FIFO)
//   push/din : write a byte; accepted when not full, or when full with a pop
//   pop      : remove the head; ignored when empty
//   dout     : combinational head byte, 8'h00 when empty
//   empty, full, level : occupancy
module debug_uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == LW'(DEPTH));
  assign level = count;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts
  // a push that coincides with a pop.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || pop);

  assign dout = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/debug_uart_rx.sv
// Debug UART receiver (8N1) for tinyQV, companion of the debug UART TX.
//   clk, rst     : system clock, synchronous active-high reset
//   uart_rxd     : asynchronous serial input, idle high
//   bus          : tinyQV data-bus slice (slave side): data and status registers
//   rx_interrupt : level interrupt, high while received bytes are unread
//
// Receive FSM:
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a falling edge
//   RX_START | half a bit in, confirm the start bit is still low
//   RX_DATA  | sample 8 data bits LSB-first, one per bit time
//   RX_STOP  | sample stop bit; high pushes the byte, low is a framing error
//   RX_BREAK | line held low after a framing error, wait for it to go high
module debug_uart_rx
  import debug_uart_rx_pkg::*;
#(
  parameter int CLOCK_MHZ  = 14,
  parameter int BIT_RATE   = 1_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rxd,
  debug_uart_rx_if.slave  bus,
  output logic            rx_interrupt
);
  localparam int CLKS_PER_BIT = CLOCK_MHZ * 1_000_000 / BIT_RATE;
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam int LW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);

  logic            rxd_m, rxd_s, rxd_p;
  rx_state_e       state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            push_q;
  logic            ferr_pulse;
  logic            overrun, framing_err;
  logic            fifo_empty, fifo_full;
  logic [7:0]      fifo_head;
  logic [LW-1:0]   fifo_level;
  logic            rd_req, clr_req;
  logic            unused_data_in;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      push_q     <= 1'b0;
      ferr_pulse <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rxd_p && !rxd_s) begin
            timer <= HALF_RELOAD;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (timer == '0) begin
            if (!rxd_s) begin
              timer   <= BIT_RELOAD;
              bit_idx <= '0;
              state   <= RX_DATA;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RX_DATA: begin
          if (timer == '0) begin
            shift <= {rxd_s, shift[7:1]};
            timer <= BIT_RELOAD;
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RX_STOP: begin
          if (timer == '0) begin
            if (rxd_s) begin
              push_q <= 1'b1;
              state  <= RX_IDLE;
            end else begin
              ferr_pulse <= 1'b1;
              state      <= RX_BREAK;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RX_BREAK: begin
          if (rxd_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign rd_req  = bus.sel_data && is_access(bus.data_read_n);
  assign clr_req = bus.sel_status && is_access(bus.data_write_n);

  // shift stays stable from the last data bit until the next frame starts,
  // so it can feed the FIFO directly when push_q fires.
  debug_uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (rd_req),
    .din   (shift),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Sticky flags: a new error in the same cycle as a clear write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (push_q && fifo_full && !rd_req) overrun <= 1'b1;
      else if (clr_req && bus.data_in[2])  overrun <= 1'b0;
      if (ferr_pulse)                          framing_err <= 1'b1;
      else if (clr_req && bus.data_in[3])      framing_err <= 1'b0;
    end
  end

  always_comb begin
    bus.data_out = 32'hFFFF_FFFF;
    if (bus.sel_data) begin
      bus.data_out = {23'h0, !fifo_empty, fifo_head};
    end else if (bus.sel_status) begin
      bus.data_out = 32'h0;
      bus.data_out[ST_NONEMPTY]           = !fifo_empty;
      bus.data_out[ST_FULL]               = fifo_full;
      bus.data_out[ST_OVERRUN]            = overrun;
      bus.data_out[ST_FRAMING]            = framing_err;
      bus.data_out[ST_LEVEL_LSB +: 8]     = {{(8 - LW){1'b0}}, fifo_level};
    end
  end

  assign bus.data_ready = 1'b1;
  assign rx_interrupt   = !fifo_empty;

  assign unused_data_in = ^{bus.data_in[31:4], bus.data_in[1:0]};
endmodule

// File: tb/tb_debug_uart_rx.sv
// Randomised self-checking bench for debug_uart_rx against a queue-based
// model of the receive FIFO and sticky flags.
module tb_debug_uart_rx;
  localparam int CPB   = 14;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rxd = 1'b1;
  logic rx_interrupt;

  debug_uart_rx_if bus();

  debug_uart_rx #(.CLOCK_MHZ(14), .BIT_RATE(1_000_000), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .bus          (bus),
    .rx_interrupt (rx_interrupt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit m_ovr = 0;
  bit m_ferr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'h0;
    s[15:8] = 8'(q.size());
    s[3] = m_ferr;
    s[2] = m_ovr;
    s[1] = (q.size() == DEPTH);
    s[0] = (q.size() != 0);
    return s;
  endfunction

  function automatic logic [31:0] exp_data();
    if (q.size() == 0) return 32'h0;
    return {23'h0, 1'b1, q[0]};
  endfunction

  function automatic void model_rx(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1;
  endfunction

  task automatic bus_idle();
    bus.sel_data = 1'b0;
    bus.sel_status = 1'b0;
    bus.data_read_n = 2'b11;
    bus.data_write_n = 2'b11;
    bus.data_in = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    @(negedge clk);
    bus_idle();
    bus.sel_status = 1'b1;
    #1 v = bus.data_out;
  endtask

  task automatic read_data(output logic [31:0] v);
    @(negedge clk);
    bus_idle();
    bus.sel_data = 1'b1;
    bus.data_read_n = 2'($urandom_range(0, 2));
    #1 v = bus.data_out;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic write_reg(input bit to_status, input logic [31:0] val);
    @(negedge clk);
    bus_idle();
    if (to_status) bus.sel_status = 1'b1;
    else bus.sel_data = 1'b1;
    bus.data_write_n = 2'($urandom_range(0, 2));
    bus.data_in = val;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v;
    read_status(v);
    chk({tag, "/status"}, v, exp_status());
    chk({tag, "/irq"}, 32'(rx_interrupt), 32'(q.size() != 0));
  endtask

  task automatic read_and_check(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    e = exp_data();
    read_data(v);
    chk({tag, "/data"}, v, e);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  // Sends one frame while polling the status level every cycle. act_kind 0
  // performs a data read at cycle act_at, act_kind 1 a status write of act_val.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int act_at,
                            input int act_kind, input logic [31:0] act_val,
                            output int change_at, output logic [31:0] act_rd);
    logic [9:0] bits;
    logic [31:0] lvl0;
    logic [31:0] cur;
    bit prev_rd;
    int total;
    bits = {stop, b, 1'b0};
    total = stop ? 148 : 178;
    change_at = -1;
    act_rd = 32'h0;
    lvl0 = 32'h0;
    prev_rd = 0;
    @(negedge clk);
    bus_idle();
    bus.sel_status = 1'b1;
    #1;
    for (int n = 0; n < total; n++) begin
      if (!prev_rd) begin
        cur = bus.data_out;
        if (n == 0) lvl0 = cur;
        else if (change_at < 0 && cur[15:8] != lvl0[15:8]) change_at = n;
      end
      if (n < 140) uart_rxd = bits[n / CPB];
      else uart_rxd = stop ? 1'b1 : (n >= 170);
      bus_idle();
      bus.sel_status = 1'b1;
      prev_rd = 0;
      if (n == act_at) begin
        if (act_kind == 0) begin
          bus.sel_status = 1'b0;
          bus.sel_data = 1'b1;
          bus.data_read_n = 2'b00;
          #1 act_rd = bus.data_out;
          prev_rd = 1;
        end else begin
          bus.data_write_n = 2'b00;
          bus.data_in = act_val;
        end
      end
      @(negedge clk);
      #1;
    end
    uart_rxd = 1'b1;
    bus_idle();
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int c;
    logic [31:0] r;
    send_frame(b, 1'b1, -1, 0, 32'h0, c, r);
    model_rx(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    uart_rxd = 1'b1;
    bus_idle();
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ovr = 0;
    m_ferr = 0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] rd;
    logic [7:0] b;
    int j;
    int c;
    bus_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle bus behaviour
    check_state("reset");
    read_and_check("empty_read");
    @(negedge clk);
    bus_idle();
    #1 chk("no_select", bus.data_out, 32'hFFFF_FFFF);
    chk("data_ready", 32'(bus.data_ready), 32'h1);

    // Single byte
    rx_byte(8'hA5);
    check_state("a5");
    read_data(v);
    chk("a5_read", v, 32'h0000_01A5);
    void'(q.pop_front());
    check_state("a5_after");

    // Fill to full, drain in order
    rx_byte(8'h00); rx_byte(8'hFF); rx_byte(8'h3C); rx_byte(8'hC3);
    check_state("full4");
    for (int i = 0; i < 5; i++) read_and_check("drain4");

    // Overrun and its clear
    for (int i = 0; i < 5; i++) rx_byte(8'($urandom));
    check_state("overrun");
    write_reg(1'b1, 32'h4);
    m_ovr = 0;
    check_state("ovr_clr");
    write_reg(1'b0, 32'hFFFF_FFFF);
    check_state("data_write_ignored");
    while (q.size() != 0) read_and_check("drain_ovr");

    // Framing error with held-low line, then recovery
    send_frame(8'h55, 1'b0, -1, 0, 32'h0, c, rd);
    m_ferr = 1;
    check_state("framing");
    rx_byte(8'h12);
    check_state("after_break");
    read_and_check("rx12");
    write_reg(1'b1, 32'h8);
    m_ferr = 0;
    check_state("ferr_clr");

    // Glitch on the line
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    check_state("glitch");

    // Reset in the middle of a frame
    rx_byte(8'h77);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = 1'($urandom_range(0, 1));
      repeat (CPB) @(negedge clk);
    end
    do_reset();
    check_state("mid_rst");
    rx_byte(8'h81);
    check_state("after_rst");
    read_and_check("rx81");

    // Randomised traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rx_byte(8'($urandom));
        5, 6: read_and_check("rnd_read");
        7: begin
          send_frame(8'($urandom), 1'b0, -1, 0, 32'h0, c, rd);
          m_ferr = 1;
        end
        8: begin
          v = 32'($urandom_range(0, 15));
          write_reg(1'b1, v);
          if (v[2]) m_ovr = 0;
          if (v[3]) m_ferr = 0;
        end
        default: begin
          @(negedge clk);
          uart_rxd = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge clk);
          uart_rxd = 1'b1;
          repeat (20) @(negedge clk);
        end
      endcase
      check_state("rnd");
    end

    // Pop in the exact push cycle while full, then clear racing a new overrun
    do_reset();
    for (int i = 0; i < 3; i++) rx_byte(8'($urandom));
    b = 8'($urandom);
    send_frame(b, 1'b1, -1, 0, 32'h0, j, rd);
    model_rx(b);
    chk("push_seen", 32'(j > 1), 32'h1);
    check_state("pre_race");
    b = 8'($urandom);
    v = exp_data();
    send_frame(b, 1'b1, j - 1, 0, 32'h0, c, rd);
    chk("race_read", rd, v);
    void'(q.pop_front());
    model_rx(b);
    check_state("race_pop");
    b = 8'($urandom);
    send_frame(b, 1'b1, j - 1, 1, 32'hC, c, rd);
    model_rx(b);
    check_state("race_clr");
    for (int i = 0; i < 5; i++) read_and_check("race_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
